// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared types and helpers for the register-store scheduler.
//   state_t        : access sequencer states {ST_IDLE, ST_ACCESS, ST_DONE}
//   RF_ADDR_W      : default entry address width
//   RF_DATA_W      : default entry data width
//   RF_MAX_NREQ    : largest supported requester count
//   onehot_to_idx  : converts a one-hot vector (up to 8 bits) to its index
package regfile_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int RF_ADDR_W   = 2;
    localparam int RF_DATA_W   = 2;
    localparam int RF_MAX_NREQ = 8;

    // OR of the indices of all set bits; exact for a one-hot input, 0 for all-zero.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < RF_MAX_NREQ; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_sched_rf_array.sv
// rf_array: 2**ADDR_W x DATA_W storage with one synchronous write port and one
// combinational read port. All entries clear synchronously on reset, and reset
// takes priority over a write on the same edge.
//   clk, reset : clock, synchronous active-high reset
//   i_we       : write enable
//   i_waddr    : write address
//   i_wdata    : write data
//   i_raddr    : read address
//   o_rdata    : read data (combinational from the storage registers)
module rf_array
    import regfile_sched_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage update: clear on reset, otherwise commit the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end else begin
            r_mem[i_waddr] <= r_mem[i_waddr];
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/regfile_sched.sv
// regfile_sched: arbitrates read/write requests from NREQ requesters onto the
// shared register store and runs the IDLE -> ACCESS -> DONE sequence.
// Optional macro REGFILE_SCHED_RR_EN selects round-robin arbitration; when it
// is undefined the lowest-index requester wins and no pointer is built.
//   clk, reset : clock, synchronous active-high reset
//   req        : per-requester request, held until ack
//   we         : per-requester write (1) / read (0)
//   addr       : flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata      : flattened write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        : registered one-hot grant (ACCESS and DONE)
//   ack        : registered one-cycle completion pulse (DONE)
//   rdata      : last read result, held until the next read completes
//   busy       : high whenever the sequencer is not idle
module regfile_sched
    import regfile_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NREQ);

    state_t              r_state;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
`ifdef REGFILE_SCHED_RR_EN
    logic [IDX_W-1:0]    r_ptr;
`endif

    logic                w_any;
    logic [IDX_W-1:0]    w_win_idx;
    logic [NREQ-1:0]     w_win_oh;
    logic [IDX_W-1:0]    w_widx;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic [DATA_W-1:0]   w_mem_rdata;

    // Winner search. Scanning from the far end down lets the nearest active
    // requester (relative to the start point) overwrite earlier candidates.
    always_comb begin
        w_any     = |req;
        w_win_idx = {IDX_W{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef REGFILE_SCHED_RR_EN
            w_win_idx = req[(int'(r_ptr) + k) % NREQ] ?
                        IDX_W'((int'(r_ptr) + k) % NREQ) : w_win_idx;
`else
            w_win_idx = req[k] ? IDX_W'(k) : w_win_idx;
`endif
        end
        w_win_oh            = {NREQ{1'b0}};
        w_win_oh[w_win_idx] = w_any;
    end

    // The grant register is the only record of the current winner.
    assign w_widx      = IDX_W'(onehot_to_idx(8'(r_gnt)));
    assign w_acc_addr  = addr[int'(w_widx)*ADDR_W +: ADDR_W];
    assign w_acc_wdata = wdata[int'(w_widx)*DATA_W +: DATA_W];
    assign w_mem_we    = (r_state == ST_ACCESS) && we[w_widx];

    rf_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rf_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_waddr (w_acc_addr),
        .i_wdata (w_acc_wdata),
        .i_raddr (w_acc_addr),
        .o_rdata (w_mem_rdata)
    );

    // Access sequencer with registered grant, ack, read data and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= {NREQ{1'b0}};
            r_ack   <= {NREQ{1'b0}};
            r_rdata <= {DATA_W{1'b0}};
            r_busy  <= 1'b0;
`ifdef REGFILE_SCHED_RR_EN
            r_ptr   <= {IDX_W{1'b0}};
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= {NREQ{1'b0}};
                    if (w_any) begin
                        r_gnt   <= w_win_oh;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCESS;
                    end else begin
                        r_gnt   <= {NREQ{1'b0}};
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Ack is registered here so that it is visible during DONE.
                    r_ack   <= r_gnt;
                    r_state <= ST_DONE;
                    if (!we[w_widx]) begin
                        r_rdata <= w_mem_rdata;
                    end else begin
                        r_rdata <= r_rdata;
                    end
                end
                ST_DONE: begin
                    r_ack   <= {NREQ{1'b0}};
                    r_gnt   <= {NREQ{1'b0}};
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef REGFILE_SCHED_RR_EN
                    r_ptr   <= (int'(w_widx) == NREQ - 1) ? {IDX_W{1'b0}} :
                               w_widx + IDX_W'(1);
`endif
                end
                default: begin
                    r_ack   <= {NREQ{1'b0}};
                    r_gnt   <= {NREQ{1'b0}};
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign busy  = r_busy;

endmodule

// File: tb/tb_regfile_sched.sv
// tb_regfile_sched: directed self-checking bench for regfile_sched (NREQ=4,
// ADDR_W=2, DATA_W=2). Inputs change 1 time unit after a rising edge and
// outputs are checked at the same point, i.e. away from the active edge.
module tb_regfile_sched;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [1:0] rdata;
    logic       busy;

    int n_checks;
    int n_err;

    regfile_sched #(
        .NREQ   (4),
        .ADDR_W (2),
        .DATA_W (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .rdata (rdata),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction by requester i, started from an IDLE cycle.
    task automatic txn(input int i, input logic w, input logic [1:0] a,
                       input logic [1:0] d, input logic chk_rd,
                       input logic [1:0] exp_rd, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        req[i]          = 1'b1;
        we[i]           = w;
        addr[i*2 +: 2]  = a;
        wdata[i*2 +: 2] = d;
        step();
        check({tag, ".gnt"},  8'(gnt),  8'(oh));
        check({tag, ".busy"}, 8'(busy), 8'd1);
        check({tag, ".ack0"}, 8'(ack),  8'd0);
        step();
        check({tag, ".ack"},  8'(ack),  8'(oh));
        if (chk_rd) begin
            check({tag, ".rdata"}, 8'(rdata), 8'(exp_rd));
        end
        req[i] = 1'b0;
        step();
        check({tag, ".idle_busy"}, 8'(busy), 8'd0);
        check({tag, ".idle_gnt"},  8'(gnt),  8'd0);
        check({tag, ".idle_ack"},  8'(ack),  8'd0);
    endtask

    initial begin
        logic [3:0] exp_seq [4];
        logic [3:0] exp_g;
        n_checks = 0;
        n_err    = 0;
        reset = 1'b1;
        req   = 4'd0;
        we    = 4'd0;
        addr  = 8'd0;
        wdata = 8'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst.gnt",   8'(gnt),   8'd0);
        check("rst.ack",   8'(ack),   8'd0);
        check("rst.rdata", 8'(rdata), 8'd0);
        check("rst.busy",  8'(busy),  8'd0);

        // 1: write 3 to addr 2, then read it back
        txn(0, 1'b1, 2'd2, 2'd3, 1'b0, 2'd0, "t1w");
        txn(0, 1'b0, 2'd2, 2'd0, 1'b1, 2'd3, "t1r");

        // 2: never-written entry reads 0
        txn(2, 1'b0, 2'd1, 2'd0, 1'b1, 2'd0, "t2");

        // 3: contention between requesters 0 and 2, both held high
`ifdef REGFILE_SCHED_RR_EN
        exp_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`else
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        we[0] = 1'b0; addr[1:0] = 2'd2;
        we[2] = 1'b0; addr[5:4] = 2'd2;
        req[0] = 1'b1;
        req[2] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_g = exp_seq[n];
            step();
            check($sformatf("t3.gnt%0d", n), 8'(gnt), 8'(exp_g));
            step();
            check($sformatf("t3.ack%0d", n), 8'(ack), 8'(exp_g));
            check($sformatf("t3.rd%0d", n), 8'(rdata), 8'd3);
            if (n == 3) begin
                req[0] = 1'b0;
                req[2] = 1'b0;
            end
            step();
            check($sformatf("t3.idle%0d", n), 8'(busy), 8'd0);
        end

        // 4: reset during ACCESS of a write of 3 to addr 0
        req[1] = 1'b1; we[1] = 1'b1; addr[3:2] = 2'd0; wdata[3:2] = 2'd3;
        step();
        check("t4.gnt", 8'(gnt), 8'b0010);
        reset  = 1'b1;
        req[1] = 1'b0;
        step();
        reset = 1'b0;
        check("t4.busy",  8'(busy),  8'd0);
        check("t4.ack",   8'(ack),   8'd0);
        check("t4.gnt0",  8'(gnt),   8'd0);
        check("t4.rdata", 8'(rdata), 8'd0);
        step();
        check("t4.ack_late", 8'(ack), 8'd0);
        txn(0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, "t4r");

        // 5: requester 1 drops req during ACCESS of a read of addr 2
        txn(3, 1'b1, 2'd2, 2'd2, 1'b0, 2'd0, "t5w");
        req[1] = 1'b1; we[1] = 1'b0; addr[3:2] = 2'd2;
        step();
        check("t5.gnt", 8'(gnt), 8'b0010);
        req[1] = 1'b0;
        step();
        check("t5.ack",   8'(ack),   8'b0010);
        check("t5.rdata", 8'(rdata), 8'd2);
        step();
        check("t5.ack_once", 8'(ack),  8'd0);
        check("t5.idle",     8'(busy), 8'd0);
        step();
        check("t5.no_regrant", 8'(gnt), 8'd0);

        // 6: requester 3 writes 1 to addr 3 while requester 1 read of addr 3 waits
        req[3] = 1'b1; we[3] = 1'b1; addr[7:6] = 2'd3; wdata[7:6] = 2'd1;
        step();
        check("t6.gnt_w", 8'(gnt), 8'b1000);
        req[1] = 1'b1; we[1] = 1'b0; addr[3:2] = 2'd3;
        step();
        check("t6.ack_w", 8'(ack), 8'b1000);
        req[3] = 1'b0;
        step();
        check("t6.idle", 8'(busy), 8'd0);
        step();
        check("t6.gnt_r", 8'(gnt), 8'b0010);
        step();
        check("t6.ack_r",   8'(ack),   8'b0010);
        check("t6.rdata_r", 8'(rdata), 8'd1);
        req[1] = 1'b0;
        step();
        check("t6.end", 8'(busy), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sched.md
# regfile_sched

Scheduler and sequencer for the shared 4-entry × 2-bit state/register store in the FSM-PP datapath. Accepts read/write requests from up to `NREQ` requesters, arbitrates one winner at a time, and runs a fixed three-state access sequence. The winner gets a one-hot grant, a single-cycle ack, and read data. It sits between the per-requester control FSMs and the storage array, and it is the only writer of that array.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 2: entry address width; depth = 2**`ADDR_W`.
- `DATA_W`, 2: entry data width.

Ports:
- `clk`, in, 1: clock. All state changes on its rising edge.
- `reset`, in, 1: reset; synchronous, active-high.
- `req`, in, `NREQ`: request per requester. Held high until the matching `ack`.
- `we`, in, `NREQ`: per requester, 1 = write, 0 = read. Stable while `req` is high.
- `addr`, in, `NREQ`*`ADDR_W`: flattened addresses; requester i uses slice [i*`ADDR_W` +: `ADDR_W`].
- `wdata`, in, `NREQ`*`DATA_W`: flattened write data, sliced the same way.
- `gnt`, out, `NREQ`: one-hot grant, registered.
- `ack`, out, `NREQ`: one-cycle completion pulse to the winner.
- `rdata`, out, `DATA_W`: read result; holds its value until the next read completes.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
States:
- **IDLE**
  - If any `req` bit is high: select a winner `w`, set `gnt` <= onehot(`w`), go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - Sample `we[w]`, `addr[w]` and `wdata[w]`.
  - Write: `mem[addr]` <= `wdata` at the end of the cycle.
  - Read: `rdata` <= `mem[addr]`.
  - Go to DONE.
- **DONE**
  - `ack[w]` = 1 for this cycle only.
  - `gnt` <= 0 at the exit edge.
  - Update the priority pointer.
  - Go to IDLE.

Arbitration:
- Only `req` sampled in IDLE is considered. Requests arriving in ACCESS or DONE wait.
- Winner selection is covered under Configuration.

Boundary rules:
- **`req[w]` dropped in ACCESS or DONE:** the access still completes and `ack[w]` still pulses. There is no abort.
- **Requester handshake:** a requester drops `req` on the edge after it sees `ack`. If it keeps `req` high in IDLE, that counts as a new request.
- **Never-written entries:** read as 0.
- **Address range:** every address is in range by construction (full 2**`ADDR_W` decode).
- **Write followed by read of the same entry:** the read returns the new value, because the write commits at the end of ACCESS of the earlier transaction.
- **Reset mid-operation:**
  - The transaction is abandoned and no `ack` is issued.
  - A write whose ACCESS edge coincides with `reset` is not committed; `reset` has priority.

## Timing
Reset values:
- `gnt`, `ack`, `rdata`, `busy`: 0.
- All `mem` entries: 0.
- Priority pointer: 0.
- State: IDLE.

Cycle sequence, with `req` first high in IDLE cycle T:
- T+1: ACCESS; `gnt` is valid.
- T+2: DONE; `ack` = 1 and `rdata` is valid.
- T+3: IDLE; the next request can be sampled.

Summary:
- Latency from request to ack is 2 cycles.
- Throughput is one access per 3 cycles.
- `gnt` is high for exactly 2 cycles per transaction.

## Configuration
Macro `REGFILE_SCHED_RR_EN`:
- **Defined (round-robin):**
  - The search starts at the pointer and wraps modulo `NREQ`.
  - In DONE, the pointer becomes (`w`+1) mod `NREQ`.
- **Undefined (fixed priority):**
  - The lowest-index active requester wins.
  - The pointer register is not built.

## Structure
Shared package `regfile_sched_pkg` holds:
- The state enum {IDLE, ACCESS, DONE}.
- Default widths `ADDR_W` and `DATA_W`.
- A onehot-to-index helper function.

Sub-module `rf_array`:
- 2**`ADDR_W` × `DATA_W` storage.
- One synchronous write port and one read port.
- Synchronous clear on `reset`.

The arbiter and FSM stay in `regfile_sched`.

## Test plan
1. **Single write, then read:** after reset, requester 0 writes `addr`=2, `wdata`=3, then reads `addr`=2.
   - Write: `gnt`=0001 in cycle T+1, `ack[0]` in cycle T+2.
   - Read: `rdata`=3 in the read's DONE cycle.
2. **Unwritten entry:** read `addr`=1 with no prior write -> `rdata`=0, `ack` after 2 cycles.
3. **Contention:** `req[0]` and `req[2]` held permanently high.
   - With `REGFILE_SCHED_RR_EN`: grants go 0, 2, 0, 2.
   - Without it: grants go 0, 0, 0.
   - Every transaction is 3 cycles apart.
4. **Reset during a write:** assert `reset` during ACCESS of a write of 3 to `addr`=0 -> no `ack`, `busy`=0 next cycle, later read of `addr`=0 returns 0.
5. **Requester drops early:** requester 1 deasserts `req` during ACCESS -> access still completes, `ack[1]` pulses once in DONE.
6. **Write then read, different requesters:** requester 3 writes 1 to `addr`=3 while requester 1 has a read of `addr`=3 pending -> the read, served next, returns `rdata`=1.
